// File: rtl/cache_ram_arbiter_pkg.sv
// Shared definitions for the cache/RAM-interface arbiter: FSM encoding, master indices, default widths.
// Round-robin arbitration is enabled by defining CACHE_RAM_ARB_RR_EN.
package cache_ram_arbiter_pkg;

    localparam int DEF_ADDR_SIZE      = 13;
    localparam int DEF_CASH_STR_WIDTH = 64;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BUSY    = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = IDLE,
        ST_BUSY    = BUSY,
        ST_RELEASE = RELEASE
    } arb_state_t;

    localparam logic M_ICACHE = 1'b0;
    localparam logic M_DCACHE = 1'b1;

endpackage

// File: rtl/cache_ram_arbiter_pick2.sv
// Combinational two-way pick. With CACHE_RAM_ARB_RR_EN the ptr input names the master preferred
// on a tie; otherwise master 0 always wins ties and ptr is not used.
module arb_pick2
    import cache_ram_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       valid,
    output logic       grant
);

`ifndef CACHE_RAM_ARB_RR_EN
    logic unused_ptr_s;
    assign unused_ptr_s = ptr;
`endif

    // Winner selection from the request vector
    always_comb begin
        valid = req[0] | req[1];
        grant = M_ICACHE;
`ifdef CACHE_RAM_ARB_RR_EN
        if (req[0] && req[1]) begin
            grant = ptr;
        end else if (req[1]) begin
            grant = M_DCACHE;
        end else begin
            grant = M_ICACHE;
        end
`else
        if (req[0]) begin
            grant = M_ICACHE;
        end else if (req[1]) begin
            grant = M_DCACHE;
        end else begin
            grant = M_ICACHE;
        end
`endif
    end

endmodule

// File: rtl/cache_ram_arbiter.sv
// Two-master arbiter (icache = master 0, dcache = master 1) in front of the RAM interface cache port.
// Define CACHE_RAM_ARB_RR_EN for round-robin tie-breaking; default is fixed priority to master 0.
module cache_ram_arbiter
    import cache_ram_arbiter_pkg::*;
#(
    parameter int ADDR_SIZE      = DEF_ADDR_SIZE,
    parameter int CASH_STR_WIDTH = DEF_CASH_STR_WIDTH
)
(
    input  logic                      clk,
    input  logic                      not_reset,
    input  logic                      m0_avalid,
    input  logic                      m0_rnw,
    input  logic [ADDR_SIZE-1:0]      m0_addr,
    input  logic [CASH_STR_WIDTH-1:0] m0_wdata,
    output logic [CASH_STR_WIDTH-1:0] m0_rdata,
    output logic                      m0_ack,
    input  logic                      m1_avalid,
    input  logic                      m1_rnw,
    input  logic [ADDR_SIZE-1:0]      m1_addr,
    input  logic [CASH_STR_WIDTH-1:0] m1_wdata,
    output logic [CASH_STR_WIDTH-1:0] m1_rdata,
    output logic                      m1_ack,
    output logic                      ri_avalid,
    output logic                      ri_rnw,
    output logic [ADDR_SIZE-1:0]      ri_addr,
    output logic [CASH_STR_WIDTH-1:0] ri_wdata,
    input  logic [CASH_STR_WIDTH-1:0] ri_rdata,
    input  logic                      ri_ack
);

    arb_state_t                state_r;
    arb_state_t                state_s;
    logic [1:0]                req_s;
    logic                      pick_valid_s;
    logic                      pick_grant_s;
    logic                      ptr_s;
    logic                      grant_r;
    logic                      ri_avalid_r;
    logic                      ri_rnw_r;
    logic [ADDR_SIZE-1:0]      ri_addr_r;
    logic [CASH_STR_WIDTH-1:0] ri_wdata_r;
    logic [CASH_STR_WIDTH-1:0] m0_rdata_r;
    logic [CASH_STR_WIDTH-1:0] m1_rdata_r;
    logic                      m0_ack_r;
    logic                      m1_ack_r;

    assign req_s = {m1_avalid, m0_avalid};

`ifdef CACHE_RAM_ARB_RR_EN
    logic ptr_r;

    // Tie-break pointer: after each grant the other master becomes preferred
    always_ff @(posedge clk or negedge not_reset) begin
        if (!not_reset) begin
            ptr_r <= M_ICACHE;
        end else if ((state_r == ST_IDLE) && pick_valid_s) begin
            ptr_r <= ~pick_grant_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr_s = ptr_r;
`else
    assign ptr_s = M_ICACHE;
`endif

    arb_pick2 u_pick (
        .req   (req_s),
        .ptr   (ptr_s),
        .valid (pick_valid_s),
        .grant (pick_grant_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge not_reset) begin
        if (!not_reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    state_s = ST_BUSY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (ri_ack) begin
                    state_s = ST_RELEASE;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            ST_RELEASE: state_s = ST_IDLE;
            default:    state_s = ST_IDLE;
        endcase
    end

    // Downstream request latch, read-line capture and completion pulses
    always_ff @(posedge clk or negedge not_reset) begin
        if (!not_reset) begin
            grant_r     <= M_ICACHE;
            ri_avalid_r <= 1'b0;
            ri_rnw_r    <= 1'b1;
            ri_addr_r   <= {ADDR_SIZE{1'b0}};
            ri_wdata_r  <= {CASH_STR_WIDTH{1'b0}};
            m0_rdata_r  <= {CASH_STR_WIDTH{1'b0}};
            m1_rdata_r  <= {CASH_STR_WIDTH{1'b0}};
            m0_ack_r    <= 1'b0;
            m1_ack_r    <= 1'b0;
        end else begin
            m0_ack_r <= 1'b0;
            m1_ack_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pick_valid_s) begin
                        grant_r     <= pick_grant_s;
                        ri_avalid_r <= 1'b1;
                        ri_rnw_r    <= pick_grant_s ? m1_rnw   : m0_rnw;
                        ri_addr_r   <= pick_grant_s ? m1_addr  : m0_addr;
                        ri_wdata_r  <= pick_grant_s ? m1_wdata : m0_wdata;
                    end
                end
                ST_BUSY: begin
                    if (ri_ack) begin
                        ri_avalid_r <= 1'b0;
                        if (grant_r == M_DCACHE) begin
                            m1_ack_r <= 1'b1;
                            if (ri_rnw_r) begin
                                m1_rdata_r <= ri_rdata;
                            end
                        end else begin
                            m0_ack_r <= 1'b1;
                            if (ri_rnw_r) begin
                                m0_rdata_r <= ri_rdata;
                            end
                        end
                    end
                end
                default: begin
                    ri_avalid_r <= ri_avalid_r;
                end
            endcase
        end
    end

    assign ri_avalid = ri_avalid_r;
    assign ri_rnw    = ri_rnw_r;
    assign ri_addr   = ri_addr_r;
    assign ri_wdata  = ri_wdata_r;
    assign m0_rdata  = m0_rdata_r;
    assign m1_rdata  = m1_rdata_r;
    assign m0_ack    = m0_ack_r;
    assign m1_ack    = m1_ack_r;

endmodule
